// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO UART/perf-counter controller; MMIO_BRANCH_CNT_EN adds branch counters
module mmio_uart_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              inst_retire
`ifdef MMIO_BRANCH_CNT_EN
  ,
  input  logic              branch_taken,
  input  logic              branch_mispred
`endif
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);

  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_RX     = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_CYC    = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_INST   = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_CLR    = ADDR_W'(32'h18);
`ifdef MMIO_BRANCH_CNT_EN
  localparam logic [ADDR_W-1:0] A_BR     = ADDR_W'(32'h1C);
  localparam logic [ADDR_W-1:0] A_MIS    = ADDR_W'(32'h20);
`endif

  logic [7:0]       mem_q [TX_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cyc_q, inst_q;
`ifdef MMIO_BRANCH_CNT_EN
  logic [CNT_W-1:0] br_q, mis_q;
`endif
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q;

  logic load, store, full, pop, push_req, push_ok, ovf_evt, status_rd, cnt_clr;
  logic unused_wdata;

  assign load      = req_valid & ~req_we;
  assign store     = req_valid & req_we;
  assign full      = (count_q == DEPTH_C);
  assign tx_valid  = (count_q != '0);
  assign pop       = tx_valid & tx_ready;
  assign push_req  = store & (req_addr == A_TX) & req_be[0];
  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign push_ok   = push_req & (~full | pop);
  assign ovf_evt   = push_req & full & ~pop;
  assign status_rd = load & (req_addr == A_STATUS);
  assign cnt_clr   = store & (req_addr == A_CLR) & (|req_be);

  assign rx_ready  = load & (req_addr == A_RX) & rx_valid;
  assign tx_data   = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  assign unused_wdata = ^req_wdata[31:8];

  // Load data mux: reflects register state before the sampling edge
  always_comb begin
    rd_data_d = '0;
    case (req_addr)
      A_STATUS: rd_data_d = {29'b0, ovf_q, rx_valid, ~full};
      A_RX:     rd_data_d = rx_valid ? {24'b0, rx_data} : 32'b0;
      A_CYC:    rd_data_d[CNT_W-1:0] = cyc_q;
      A_INST:   rd_data_d[CNT_W-1:0] = inst_q;
`ifdef MMIO_BRANCH_CNT_EN
      A_BR:     rd_data_d[CNT_W-1:0] = br_q;
      A_MIS:    rd_data_d[CNT_W-1:0] = mis_q;
`endif
      default:  rd_data_d = '0;
    endcase
  end

  // TX FIFO storage; contents are qualified by count_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= req_wdata[7:0];
  end

  // TX FIFO pointers, occupancy and sticky overflow (set beats status-read clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
      if (ovf_evt)        ovf_q <= 1'b1;
      else if (status_rd) ovf_q <= 1'b0;
    end
  end

  // Performance counters: clear has priority over increment, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      inst_q <= '0;
`ifdef MMIO_BRANCH_CNT_EN
      br_q   <= '0;
      mis_q  <= '0;
`endif
    end else if (cnt_clr) begin
      cyc_q  <= '0;
      inst_q <= '0;
`ifdef MMIO_BRANCH_CNT_EN
      br_q   <= '0;
      mis_q  <= '0;
`endif
    end else begin
      cyc_q  <= cyc_q + 1'b1;
      inst_q <= inst_q + CNT_W'(inst_retire);
`ifdef MMIO_BRANCH_CNT_EN
      br_q   <= br_q + CNT_W'(branch_taken);
      mis_q  <= mis_q + CNT_W'(branch_mispred);
`endif
    end
  end

  // Registered read response: one-cycle pulse per accepted load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= load;
      if (load) rd_data_q <= rd_data_d;
    end
  end

endmodule
